// File: rtl/inst_mem_responder_if.sv
// Instruction-fetch memory bus between the fetch stage (master) and the
// instruction memory responder (slave). Carries the fetch request channel,
// the in-order response channel, the redirect flush and the preload port.
//
// Handshake rules for both channels:
// - A transfer happens on a rising clk edge where valid && ready.
// - req_ready does not depend on req_valid.
// - resp_valid does not depend on resp_ready.
// - Once resp_valid is high, resp_data/resp_addr/resp_err stay stable until
//   the transfer completes or a flush/reset discards the entry.
interface inst_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              flush;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic [ADDR_W-1:0] resp_addr;
   logic              resp_err;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;

   modport master (
      output req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
      input  req_ready, resp_valid, resp_data, resp_addr, resp_err
   );

   modport slave (
      input  req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
      output req_ready, resp_valid, resp_data, resp_addr, resp_err
   );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: word-addressed RAM behind a fixed-latency
// read pipeline and a response FIFO. Requests are credit limited so the
// pipeline never stalls; flush/reset drop everything in flight.
// Optional statistics counters are built when INST_MEM_RESP_STATS_EN is defined.
module inst_mem_responder #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH_WORDS = 4096,
   parameter logic [ADDR_W-1:0] MEM_BASE    = ADDR_W'(32'h8000_0000),
   parameter int                LATENCY     = 2,
   parameter int                FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef INST_MEM_RESP_STATS_EN
   output logic [31:0]           stat_req_cnt,
   output logic [31:0]           stat_err_cnt,
   output logic [31:0]           stat_flush_cnt,
`endif
   inst_mem_responder_if.slave   bus
);

   localparam int                IDX_W    = $clog2(DEPTH_WORDS);
   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [ADDR_W-1:0] MEM_LAST = MEM_BASE + ADDR_W'(4 * DEPTH_WORDS - 4);
   localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);

   // Instruction RAM (not reset)
   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   // Read pipeline: index 0 is loaded at acceptance, LATENCY-1 feeds the FIFO
   logic              r_pv [LATENCY];
   logic              r_pe [LATENCY];
   logic [ADDR_W-1:0] r_pa [LATENCY];
   logic [DATA_W-1:0] r_pd [LATENCY];

   // Response FIFO; pointers carry one extra wrap bit to tell full from empty
   logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
   logic              r_fe [FIFO_DEPTH];
   logic [CNT_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_rd_ptr;

   // Entries in the pipeline plus entries in the FIFO
   logic [CNT_W-1:0]  r_outstanding;

   logic              w_req_legal;
   logic              w_load_legal;
   logic [IDX_W-1:0]  w_req_idx;
   logic [IDX_W-1:0]  w_load_idx;
   logic              w_req_ready;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_fifo_empty;
   logic [PTR_W-1:0]  w_rd_slot;
   logic [PTR_W-1:0]  w_wr_slot;

   assign w_req_legal  = (bus.req_addr[1:0] == 2'b00) &&
                         (bus.req_addr >= MEM_BASE) && (bus.req_addr <= MEM_LAST);
   assign w_load_legal = (bus.load_addr[1:0] == 2'b00) &&
                         (bus.load_addr >= MEM_BASE) && (bus.load_addr <= MEM_LAST);
   assign w_req_idx    = IDX_W'((bus.req_addr - MEM_BASE) >> 2);
   assign w_load_idx   = IDX_W'((bus.load_addr - MEM_BASE) >> 2);

   // One credit per FIFO slot, so whatever enters the pipeline has a slot waiting
   assign w_req_ready  = !rst && !bus.flush && (r_outstanding < CNT_W'(FIFO_DEPTH));
   assign w_accept     = bus.req_valid && w_req_ready;

   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_rd_slot    = r_rd_ptr[PTR_W-1:0];
   assign w_wr_slot    = r_wr_ptr[PTR_W-1:0];
   assign w_push       = r_pv[LATENCY-1];
   assign w_pop        = !w_fifo_empty && bus.resp_ready;

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = !w_fifo_empty;
   assign bus.resp_data  = w_fifo_empty ? '0   : r_fd[w_rd_slot];
   assign bus.resp_addr  = w_fifo_empty ? '0   : r_fa[w_rd_slot];
   assign bus.resp_err   = w_fifo_empty ? 1'b0 : r_fe[w_rd_slot];

   // Loader write port; a read on the same edge sees the old word
   always_ff @(posedge clk) begin
      if (bus.load_en && w_load_legal) begin
         r_mem[w_load_idx] <= bus.load_data;
      end
   end

   // Pipeline valid bits; flush and reset drop every in-flight fetch
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int i = 0; i < LATENCY; i++) r_pv[i] <= 1'b0;
      end else begin
         r_pv[0] <= w_accept;
         for (int i = 1; i < LATENCY; i++) r_pv[i] <= r_pv[i-1];
      end
   end

   // Pipeline payload: RAM sampled at acceptance, faulting fetches carry a NOP
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pa[0] <= bus.req_addr;
         r_pe[0] <= !w_req_legal;
         r_pd[0] <= w_req_legal ? r_mem[w_req_idx] : NOP_WORD;
      end
      for (int i = 1; i < LATENCY; i++) begin
         r_pa[i] <= r_pa[i-1];
         r_pe[i] <= r_pe[i-1];
         r_pd[i] <= r_pd[i-1];
      end
   end

   // FIFO storage written from the last pipeline stage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fd[w_wr_slot] <= r_pd[LATENCY-1];
         r_fa[w_wr_slot] <= r_pa[LATENCY-1];
         r_fe[w_wr_slot] <= r_pe[LATENCY-1];
      end
   end

   // FIFO pointers; a pop coinciding with flush counts as consumed
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Outstanding counter: +1 on accept, -1 on response handshake
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_outstanding <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

`ifdef INST_MEM_RESP_STATS_EN
   logic [31:0] r_stat_req;
   logic [31:0] r_stat_err;
   logic [31:0] r_stat_flush;
   logic [31:0] w_discard;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   // Entries thrown away by a flush: everything outstanding except a same-edge pop
   assign w_discard = 32'(r_outstanding - CNT_W'(w_pop));

   // Saturating activity counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_req   <= '0;
         r_stat_err   <= '0;
         r_stat_flush <= '0;
      end else begin
         if (w_accept)                 r_stat_req   <= sat_add(r_stat_req, 32'd1);
         if (w_accept && !w_req_legal) r_stat_err   <= sat_add(r_stat_err, 32'd1);
         if (bus.flush)                r_stat_flush <= sat_add(r_stat_flush, w_discard);
      end
   end

   assign stat_req_cnt   = r_stat_req;
   assign stat_err_cnt   = r_stat_err;
   assign stat_flush_cnt = r_stat_flush;
`endif

endmodule
